// File: rtl/m6809_pagerom_if.sv
// CPU-side bus bundle for the paged ROM slot selector: address/strobe/data in,
// socket selects and register readback out.
interface m6809_pagerom_if #(
   parameter int NSLOTS = 8
);
   logic [15:0]       adr;
   logic              rnw;
   logic              e;
   logic [7:0]        data;
   logic [7:0]        data_out;
   logic              data_oe;
   logic [NSLOTS-1:0] rom_cs_b;
   logic              romoe_b;
   logic              romwe_b;
   logic              romdis;

   modport master (
      output adr, rnw, e, data,
      input  data_out, data_oe, rom_cs_b, romoe_b, romwe_b, romdis
   );

   modport slave (
      input  adr, rnw, e, data,
      output data_out, data_oe, rom_cs_b, romoe_b, romwe_b, romdis
   );
endinterface

// File: rtl/m6809_pagerom.sv
// Maps one of NSLOTS 16K sockets into 0xC000-0xFFFF under control of a lockable,
// CPU-writable PAGE register; the vector page always selects the DIP boot slot.
module m6809_pagerom #(
   parameter int         NSLOTS   = 8,
   parameter int         SLOT_AW  = 3,
   parameter logic [7:0] RAM_MASK = 8'h00,
   parameter logic [7:0] REG_BASE = 8'hF0
) (
   input  logic                 clk,
   input  logic                 reset_b,
   input  logic [7:0]           dip,
   m6809_pagerom_if.slave       bus
);
   typedef enum logic [1:0] {
      ST_OPEN   = 2'd0,
      ST_KEY1   = 2'd1,
      ST_LOCKED = 2'd2
   } lock_e;

   localparam logic [SLOT_AW:0] NSLOTS_W = (SLOT_AW+1)'(NSLOTS);

   logic [SLOT_AW-1:0] page_q;
   logic               page_we_q;
   lock_e              lock_q;
   logic               e_meta_q, e_s_q, e_prev_q;
   logic               smp_a0_q, smp_hit_q, smp_rnw_q;
   logic [7:0]         smp_data_q;

   logic [SLOT_AW-1:0] boot_slot;
   logic [SLOT_AW-1:0] slot;
   logic               win, vec, reg_hit, commit;
   logic [7:0]         page_rd;
   logic               dip_unused;

   assign dip_unused = ^dip;
   assign boot_slot  = ({1'b0, dip[SLOT_AW-1:0]} < NSLOTS_W) ? dip[SLOT_AW-1:0] : '0;

   // Decode works straight off the raw bus so selects follow the CPU without clk latency.
   assign win     = (bus.adr[15:14] == 2'b11) && (bus.adr[15:8] != 8'hFE);
   assign vec     = (bus.adr[15:4] == 12'hFFF);
   assign slot    = vec ? boot_slot : page_q;
   assign reg_hit = (bus.adr[15:8] == 8'hFE) && (bus.adr[7:1] == REG_BASE[7:1]);

   generate
      for (genvar gi = 0; gi < NSLOTS; gi++) begin : g_cs
         assign bus.rom_cs_b[gi] = !(reset_b && win && (slot == SLOT_AW'(gi)));
      end
   endgenerate

   assign bus.romoe_b = !(reset_b && bus.e && bus.rnw && win);
   assign bus.romwe_b = !(reset_b && bus.e && !bus.rnw && win && !vec &&
                          page_we_q && RAM_MASK[page_q]);
   assign bus.data_oe = reset_b && bus.e && bus.rnw && reg_hit;
   assign bus.romdis  = 1'b0;

   assign page_rd      = {page_we_q, {(7-SLOT_AW){1'b0}}, page_q};
   assign bus.data_out = !reset_b ? 8'h00 :
                         (bus.adr[0] ? {6'b0, lock_q} : page_rd);

   // The last sample before the synchronised E falls is the one the CPU completed.
   assign commit = !e_s_q && e_prev_q && smp_hit_q && !smp_rnw_q;

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         e_meta_q   <= 1'b0;
         e_s_q      <= 1'b0;
         e_prev_q   <= 1'b0;
         smp_a0_q   <= 1'b0;
         smp_hit_q  <= 1'b0;
         smp_rnw_q  <= 1'b0;
         smp_data_q <= 8'h00;
         page_q     <= boot_slot;
         page_we_q  <= 1'b0;
         lock_q     <= dip[3] ? ST_LOCKED : ST_OPEN;
      end else begin
         e_meta_q <= bus.e;
         e_s_q    <= e_meta_q;
         e_prev_q <= e_s_q;
         if (e_s_q) begin
            smp_a0_q   <= bus.adr[0];
            smp_hit_q  <= reg_hit;
            smp_rnw_q  <= bus.rnw;
            smp_data_q <= bus.data;
         end
         if (commit) begin
            if (!smp_a0_q) begin
               case (lock_q)
                  ST_OPEN: begin
                     if ({1'b0, smp_data_q[SLOT_AW-1:0]} < NSLOTS_W) begin
                        page_q    <= smp_data_q[SLOT_AW-1:0];
                        page_we_q <= smp_data_q[7];
                     end
                  end
                  ST_KEY1: lock_q <= ST_LOCKED;
                  default: ;
               endcase
            end else begin
               case (lock_q)
                  ST_OPEN:   if (smp_data_q == 8'h00) lock_q <= ST_LOCKED;
                  ST_LOCKED: if (smp_data_q == 8'h55) lock_q <= ST_KEY1;
                  ST_KEY1:   lock_q <= (smp_data_q == 8'hAA) ? ST_OPEN : ST_LOCKED;
                  default:   lock_q <= ST_LOCKED;
               endcase
            end
         end
      end
   end
endmodule
